sine_dual_sched: RTL
====================

Name: sine_dual_sched

Overview:
- Two-channel sine sequencer that time-shares one quarter-wave ROM (1-cycle registered read, 128 x 9-bit) between two phase-accumulator channels.
- Per channel: a programmable frequency word, quadrant folding of ROM address and data, and a 10-bit offset-binary DAC code.
- Sits between the shared memory instance and the two parallel DAC pin groups; replaces per-channel free-running counters.

Parameters:
- PHASE_W, 16, phase accumulator width; top 9 bits form the quadrant+index, lower bits are fractional.
- ADDR_W, 7, ROM address width (quarter-wave entries = 2^ADDR_W).
- DATA_W, 9, ROM data width.
- OUT_W, 10, DAC code width; midscale = 2^(OUT_W-1) = 512.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run sequencing; sampled at each frame start.
- freq0  in  PHASE_W  channel 0 phase increment per frame.
- freq1  in  PHASE_W  channel 1 phase increment per frame.
- freq_load  in  1  strobe: capture freq0/freq1 into shadow registers.
- sync  in  1  strobe: zero both phase accumulators at next frame start.
- rom_addr  out  ADDR_W  address to shared ROM.
- rom_data  in  DATA_W  ROM read data, valid one cycle after rom_addr.
- out0  out  OUT_W  channel 0 DAC code.
- out1  out  OUT_W  channel 1 DAC code.
- valid0  out  1  one-cycle pulse: out0 updated this cycle.
- valid1  out  1  one-cycle pulse: out1 updated this cycle.

Behaviour:
- Reset (async, rst_n=0): state S_IDLE; phase0 = phase1 = 0; freq shadows = 0; pending sync = 0; out0 = out1 = 512; valid0 = valid1 = 0; rom_addr = 0.
- FSM states: S_IDLE, S_CH0, S_CH1, S_DRAIN. One frame = S_CH0 followed by S_CH1 (2 cycles). Each channel gets one sample per frame.
- S_IDLE -> S_CH0 when enable=1.
- S_CH0 -> S_CH1 unconditionally.
- S_CH1 -> S_CH0 if enable=1, else S_DRAIN.
- S_DRAIN -> S_CH0 if enable=1, else S_IDLE.
- S_DRAIN exists only to capture channel 1's in-flight ROM data.
- Frame start is the first cycle of S_CH0. At frame start:
  - If a sync is pending, phase0/phase1 are treated as 0 for this frame and the pending flag clears.
  - freq shadows written by freq_load are used from the first frame start after the load.
- Address folding from phase p:
  - q = p[PHASE_W-1:PHASE_W-2], idx = p[PHASE_W-3:PHASE_W-2-ADDR_W].
  - rom_addr = idx for q in {0,2}; rom_addr = 127 - idx for q in {1,3}.
- Issue: in S_CH0, drive rom_addr from phase0 and register q0; phase0 += freq0 at the end of the cycle. In S_CH1, do the same for channel 1 (phase1 += freq1). Wrap is modulo 2^PHASE_W.
- Capture (rom_data arrives one cycle after issue):
  - In S_CH1: out0 <= (q0 < 2) ? 512 + rom_data : 512 - rom_data, zero-extended to OUT_W. valid0 is high the next cycle.
  - In the cycle after S_CH1 (S_CH0 or S_DRAIN): out1 is captured the same way. valid1 is high the next cycle.
- Latency: issue-to-out = 2 cycles. Each valid pulses once per frame.
- Outputs hold their last value while idle. Output never reaches 1024: max is 512+511 = 1023; min is 512-511 = 1.
- enable deasserted in S_CH0: the frame completes (S_CH1, S_DRAIN), then S_IDLE. No partial frame is ever dropped.
- Simultaneous freq_load and sync: both take effect at the same next frame start.
- freq_load while idle: applied at the first frame after enable.
- Reset asserted mid-frame: immediate return to reset values. The in-flight ROM result is discarded.

Decomposition:
- Shared package sine_pkg holds:
  - state enum sched_state_t {S_IDLE, S_CH0, S_CH1, S_DRAIN};
  - MIDSCALE constant (512);
  - quadrant_t (2-bit).
- One natural sub-module, sine_fold: combinational phase -> {rom_addr, quadrant} plus quadrant+data -> DAC code. It is instantiated once and muxed per state.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> out0 = out1 = 512, valid0 = valid1 = 0, rom_addr = 0, state S_IDLE. Release, enable=0 -> nothing changes.
- Stepping: ROM model data = 4*addr; freq0 = 128 (loaded), enable=1 -> channel 0 rom_addr sequence 0,1,2,... each frame; out0 = 512, 516, 520, ...; valid0 at a 2-cycle period.
- Quadrant folding: sync, freq0 = 0x3F80 -> frame 1 issues addr 0; frame 2 phase 0x3F80 -> addr 127, out0 = 512+508; frame 3 phase 0x7F00 (q1, idx 126) -> addr 1, out0 = 516; phase 0x8000 (q2) -> addr 0, out0 = 512-0; phase 0xC000 (q3) -> addr 127, out0 = 4.
- Channel isolation: freq0 = 128, freq1 = 256 -> channel 1 addr advances by 2 per frame. Channel 0/1 addresses alternate on rom_addr; out1 lags out0 by one cycle.
- Enable drop: deassert enable during S_CH0 -> exactly one more valid0 and one more valid1, then idle with outputs held.
- freq_load/sync timing: pulse freq_load (freq0 = 256) together with sync mid-frame -> current frame unchanged; next frame issues addr 0 for both channels, the following frame addr 2 for channel 0.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared types and constants for the dual-channel sine sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sine_pkg;

    // Scheduler states: one frame is S_CH0 then S_CH1; S_DRAIN catches channel 1's last ROM read.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CH0   = 2'd1,
        S_CH1   = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_t;

    // Quarter-wave quadrant: bit 0 mirrors the ROM address, bit 1 negates the sample.
    typedef logic [1:0] quadrant_t;

    // Offset-binary midscale for a DAC code of the given width.
    function automatic int midscale(input int out_w);
        return 1 << (out_w - 1);
    endfunction

    localparam int MIDSCALE = midscale(10);

endpackage

// File: rtl/sine_fold.sv
// Quarter-wave folding: phase -> ROM address/sign, and ROM data + sign -> DAC code.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   phase    : quadrant (2 MSBs) + table index of the channel being issued
//   addr     : folded quarter-wave ROM address
//   neg      : sign of the issued quadrant (registered by the caller until data returns)
//   data_neg : sign belonging to the sample now on data
//   data     : ROM read data
//   code     : offset-binary DAC code
module sine_fold
    import sine_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 9,
    parameter int OUT_W  = 10
) (
    input  logic [ADDR_W+1:0] phase,
    output logic [ADDR_W-1:0] addr,
    output logic              neg,
    input  logic              data_neg,
    input  logic [DATA_W-1:0] data,
    output logic [OUT_W-1:0]  code
);

    localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

    quadrant_t         quad;
    logic [ADDR_W-1:0] idx;
    logic [OUT_W-1:0]  data_ext;

    assign quad = phase[ADDR_W+1 -: 2];
    assign idx  = phase[ADDR_W-1:0];

    // Odd quadrants run the table backwards: ~idx == (2^ADDR_W - 1) - idx.
    assign addr = quad[0] ? ~idx : idx;
    assign neg  = quad[1];

    assign data_ext = OUT_W'(data);
    assign code     = data_neg ? (MID - data_ext) : (MID + data_ext);

endmodule

// File: rtl/sine_dual_sched.sv
// Two-channel sine sequencer time-sharing one registered quarter-wave ROM.
// Latency: 2 cycles from address issue to DAC code; one sample per channel per 2-cycle frame.
// Backpressure: none; free-running while enable is high, completes the current frame on drop.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : run sequencing, sampled at frame boundaries
//   freq0, freq1        : per-channel phase increments, captured on freq_load
//   freq_load, sync     : shadow-load strobe, phase-zero strobe (both act at next frame start)
//   rom_addr, rom_data  : shared ROM port (data one cycle after address)
//   out0/valid0, out1/valid1 : DAC codes with one-cycle update pulses
module sine_dual_sched
    import sine_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 9,
    parameter int OUT_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] freq0,
    input  logic [PHASE_W-1:0] freq1,
    input  logic               freq_load,
    input  logic               sync,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [OUT_W-1:0]   out0,
    output logic [OUT_W-1:0]   out1,
    output logic               valid0,
    output logic               valid1
);

    localparam int               IDX_W = ADDR_W + 2;
    localparam logic [OUT_W-1:0] MID   = OUT_W'(midscale(OUT_W));

    sched_state_t       state;
    logic [PHASE_W-1:0] phase0, phase1;
    logic [PHASE_W-1:0] freq0_sh, freq1_sh;
    logic [PHASE_W-1:0] freq1_act;     // channel 1 increment frozen at frame start
    logic               sync_pend;
    logic               neg0, neg1;    // quadrant sign held while the ROM read is in flight
    logic               ch1_inflight;  // rom_data this cycle belongs to channel 1

    logic [PHASE_W-1:0] phase0_eff;
    logic [PHASE_W-1:0] issue_phase;
    logic [ADDR_W-1:0]  fold_addr;
    logic               fold_neg;
    logic [OUT_W-1:0]   fold_code;

    // A pending sync makes this frame start from phase zero.
    assign phase0_eff  = sync_pend ? '0 : phase0;
    assign issue_phase = (state == S_CH1) ? phase1 : phase0_eff;

    sine_fold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_fold (
        .phase    (issue_phase[PHASE_W-1 -: IDX_W]),
        .addr     (fold_addr),
        .neg      (fold_neg),
        .data_neg (ch1_inflight ? neg1 : neg0),
        .data     (rom_data),
        .code     (fold_code)
    );

    assign rom_addr = (state == S_CH0 || state == S_CH1) ? fold_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase0       <= '0;
            phase1       <= '0;
            freq0_sh     <= '0;
            freq1_sh     <= '0;
            freq1_act    <= '0;
            sync_pend    <= 1'b0;
            neg0         <= 1'b0;
            neg1         <= 1'b0;
            ch1_inflight <= 1'b0;
            out0         <= MID;
            out1         <= MID;
            valid0       <= 1'b0;
            valid1       <= 1'b0;
        end else begin
            valid0       <= 1'b0;
            valid1       <= 1'b0;
            ch1_inflight <= (state == S_CH1);

            // Shadows only feed the datapath at frame start, so a load never splits a frame.
            if (freq_load) begin
                freq0_sh <= freq0;
                freq1_sh <= freq1;
            end

            if (state == S_CH0)
                sync_pend <= sync;
            else if (sync)
                sync_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (enable)
                        state <= S_CH0;
                end
                S_CH0: begin
                    phase0    <= phase0_eff + freq0_sh;
                    freq1_act <= freq1_sh;
                    neg0      <= fold_neg;
                    if (sync_pend)
                        phase1 <= '0;
                    state <= S_CH1;
                end
                S_CH1: begin
                    phase1 <= phase1 + freq1_act;
                    neg1   <= fold_neg;
                    out0   <= fold_code;
                    valid0 <= 1'b1;
                    state  <= enable ? S_CH0 : S_DRAIN;
                end
                S_DRAIN: begin
                    state <= enable ? S_CH0 : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (ch1_inflight) begin
                out1   <= fold_code;
                valid1 <= 1'b1;
            end
        end
    end

endmodule
